// File: rtl/divide_compute_pynq_if.sv
// Start/ready handshake and operand/result bundle for the divide compute IP.
interface divide_compute_pynq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  ready;
    logic                  busy;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, ready, busy, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, ready, busy, div_by_zero
    );
endinterface

// File: rtl/divide_compute_pynq.sv
// Sequential restoring divider, one quotient bit per clock, start/ready level handshake.
// Define DIV_SIGNED_EN for two's complement operands (adds a FIX state, one extra cycle).
module divide_compute_pynq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    divide_compute_pynq_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_r;
    logic [W-1:0]  dvd_r;      // dividend bits shift out the top, quotient bits shift in below
    logic [W-1:0]  dvs_r;
    logic [W-1:0]  rem_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  quotient_r;
    logic [W-1:0]  remainder_r;
    logic          ready_r;
    logic          busy_r;
    logic          dbz_r;
`ifdef DIV_SIGNED_EN
    logic          neg_q_r;
    logic          neg_r_r;
`endif

    logic [W:0]    trial_s;
    logic [W:0]    diff_s;
    logic [W-1:0]  rem_next_s;
    logic [W-1:0]  quo_next_s;
    logic [W-1:0]  dvd_abs_s;
    logic [W-1:0]  dvs_abs_s;

    // Restoring step: the borrow out of the trial subtraction decides the quotient bit.
    always_comb begin
        trial_s = {rem_r, dvd_r[W-1]};
        diff_s  = trial_s - {1'b0, dvs_r};
        if (diff_s[W] == 1'b0) begin
            rem_next_s = diff_s[W-1:0];
            quo_next_s = {dvd_r[W-2:0], 1'b1};
        end else begin
            rem_next_s = trial_s[W-1:0];
            quo_next_s = {dvd_r[W-2:0], 1'b0};
        end
`ifdef DIV_SIGNED_EN
        if (bus.dividend[W-1]) begin
            dvd_abs_s = {W{1'b0}} - bus.dividend;
        end else begin
            dvd_abs_s = bus.dividend;
        end
        if (bus.divisor[W-1]) begin
            dvs_abs_s = {W{1'b0}} - bus.divisor;
        end else begin
            dvs_abs_s = bus.divisor;
        end
`else
        dvd_abs_s = bus.dividend;
        dvs_abs_s = bus.divisor;
`endif
    end

    // Control FSM with registered results and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            dvd_r       <= {W{1'b0}};
            dvs_r       <= {W{1'b0}};
            rem_r       <= {W{1'b0}};
            cnt_r       <= {CW{1'b0}};
            quotient_r  <= {W{1'b0}};
            remainder_r <= {W{1'b0}};
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            dbz_r       <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        ready_r <= 1'b0;
                        dbz_r   <= 1'b0;
                        cnt_r   <= CW'(W - 1);
                        dvd_r   <= dvd_abs_s;
                        dvs_r   <= dvs_abs_s;
                        rem_r   <= {W{1'b0}};
`ifdef DIV_SIGNED_EN
                        neg_q_r <= bus.dividend[W-1] ^ bus.divisor[W-1];
                        neg_r_r <= bus.dividend[W-1];
`endif
                        if (bus.divisor == {W{1'b0}}) begin
                            state_r     <= S_DONE;
                            ready_r     <= 1'b1;
                            dbz_r       <= 1'b1;
                            quotient_r  <= {W{1'b1}};
                            remainder_r <= bus.dividend;
                        end else begin
                            state_r <= S_CALC;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_CALC: begin
                    dvd_r <= quo_next_s;
                    rem_r <= rem_next_s;
                    if (cnt_r == {CW{1'b0}}) begin
`ifdef DIV_SIGNED_EN
                        state_r <= S_FIX;
`else
                        quotient_r  <= quo_next_s;
                        remainder_r <= rem_next_s;
                        ready_r     <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= S_DONE;
`endif
                    end else begin
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
`ifdef DIV_SIGNED_EN
                S_FIX: begin
                    quotient_r  <= neg_q_r ? ({W{1'b0}} - dvd_r) : dvd_r;
                    remainder_r <= neg_r_r ? ({W{1'b0}} - rem_r) : rem_r;
                    ready_r     <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= S_DONE;
                end
`endif
                S_DONE: begin
                    // No retrigger until start has been seen low here.
                    if (!bus.start) begin
                        ready_r <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_DONE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.ready       = ready_r;
    assign bus.busy        = busy_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_divide_compute_pynq.sv
// Directed bench for divide_compute_pynq (W=32); honours DIV_SIGNED_EN for latency and signed cases.
module tb_divide_compute_pynq;
`ifdef DIV_SIGNED_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   lat;
    logic busy_seen;
    logic ready_all;

    divide_compute_pynq_if #(.DATA_WIDTH(32)) bus ();

    divide_compute_pynq #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Count edges after the one that accepts start until ready, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.ready && n < 200) begin
            @(posedge clk); #1;
            busy_seen = busy_seen | bus.busy;
            n++;
        end
    endtask

    // Raise start with operands; leaves start high once ready is seen.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        busy_seen    = 1'b0;
        @(posedge clk); #1;
        busy_seen = bus.busy;
        wait_ready(lat);
    endtask

    task automatic release_start();
        bus.start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q",     bus.quotient, 32'd0);
        check("rst_r",     bus.remainder, 32'd0);
        check("rst_ready", {31'd0, bus.ready}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_dbz",   {31'd0, bus.div_by_zero}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(32'd100, 32'd7);
        check("t1_lat",  32'(lat), 32'(LAT));
        check("t1_q",    bus.quotient, 32'd14);
        check("t1_r",    bus.remainder, 32'd2);
        check("t1_dbz",  {31'd0, bus.div_by_zero}, 32'd0);
        check("t1_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("t1_busy_done", {31'd0, bus.busy}, 32'd0);
        release_start();
        check("t1_ready_drop", {31'd0, bus.ready}, 32'd0);
        check("t1_q_held", bus.quotient, 32'd14);

        do_op(32'd5, 32'd0);
        check("t2_lat",  32'(lat), 32'd0);
        check("t2_dbz",  {31'd0, bus.div_by_zero}, 32'd1);
        check("t2_q",    bus.quotient, 32'hFFFFFFFF);
        check("t2_r",    bus.remainder, 32'd5);
        check("t2_busy", {31'd0, busy_seen}, 32'd0);
        release_start();

        do_op(32'hFFFFFFFF, 32'd1);
        check("t3a_q",  bus.quotient, 32'hFFFFFFFF);
        check("t3a_r",  bus.remainder, 32'd0);
        check("t3a_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        release_start();
        do_op(32'd3, 32'd10);
        check("t3b_q", bus.quotient, 32'd0);
        check("t3b_r", bus.remainder, 32'd3);
        release_start();

        // Reset lands on E10 of a running 1000/3.
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        bus.start    = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        reset     = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t4_q0",     bus.quotient, 32'd0);
        check("t4_r0",     bus.remainder, 32'd0);
        check("t4_ready0", {31'd0, bus.ready}, 32'd0);
        check("t4_busy0",  {31'd0, bus.busy}, 32'd0);
        check("t4_dbz0",   {31'd0, bus.div_by_zero}, 32'd0);
        @(posedge clk); #1;
        do_op(32'd1000, 32'd3);
        check("t4_lat", 32'(lat), 32'(LAT));
        check("t4_q",   bus.quotient, 32'd333);
        check("t4_r",   bus.remainder, 32'd1);
        release_start();

        // Operands and start change right after acceptance; ready pulses once.
        bus.dividend = 32'd200;
        bus.divisor  = 32'd9;
        bus.start    = 1'b1;
        busy_seen    = 1'b0;
        @(posedge clk); #1;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
        bus.start    = 1'b0;
        wait_ready(lat);
        check("tc_lat", 32'(lat), 32'(LAT));
        check("tc_q",   bus.quotient, 32'd22);
        check("tc_r",   bus.remainder, 32'd2);
        check("tc_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        @(posedge clk); #1;
        check("tc_pulse", {31'd0, bus.ready}, 32'd0);

        // start held high past ready: no retrigger.
        do_op(32'd50, 32'd5);
        ready_all = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            ready_all = ready_all & bus.ready;
            busy_seen = busy_seen | bus.busy;
        end
        check("t5_ready_held", {31'd0, ready_all}, 32'd1);
        check("t5_busy_low",   {31'd0, busy_seen}, 32'd0);
        check("t5_q",          bus.quotient, 32'd10);
        release_start();
        check("t5_idle", {31'd0, bus.ready}, 32'd0);
        do_op(32'd60, 32'd4);
        check("t5_lat", 32'(lat), 32'(LAT));
        check("t5_q2",  bus.quotient, 32'd15);
        check("t5_r2",  bus.remainder, 32'd0);
        release_start();

`ifdef DIV_SIGNED_EN
        do_op(32'hFFFFFFF9, 32'd2);
        check("t6_lat", 32'(lat), 32'd33);
        check("t6_q",   bus.quotient, 32'hFFFFFFFD);
        check("t6_r",   bus.remainder, 32'hFFFFFFFF);
        release_start();
        do_op(32'h80000000, 32'hFFFFFFFF);
        check("t6_wrap_q", bus.quotient, 32'h80000000);
        check("t6_wrap_r", bus.remainder, 32'd0);
        release_start();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
